// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg
//   Shared definitions for the FIR core AXI4-Lite control slave:
//   register byte offsets, bit positions inside those registers and the
//   encodings of the write/read channel state machines.
//   No ports (package only).
package fir_ctrl_pkg;

  // Register byte offsets (word aligned)
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_GIE    = 8'h04;
  localparam logic [7:0] ADDR_IER    = 8'h08;
  localparam logic [7:0] ADDR_ISR    = 8'h0C;
  localparam logic [7:0] ADDR_X      = 8'h10;
  localparam logic [7:0] ADDR_Y      = 8'h18;
  localparam logic [7:0] ADDR_Y_CTRL = 8'h1C;

  // CTRL bit positions
  localparam int CTRL_START        = 0;
  localparam int CTRL_DONE         = 1;
  localparam int CTRL_IDLE         = 2;
  localparam int CTRL_READY        = 3;
  localparam int CTRL_AUTO_RESTART = 7;

  // GIE / ISR / Y_CTRL bit positions
  localparam int GIE_EN     = 0;
  localparam int ISR_DONE   = 0;
  localparam int ISR_READY  = 1;
  localparam int Y_CTRL_VLD = 0;

  typedef enum logic [1:0] {
    WRIDLE = 2'd0,
    WRDATA = 2'd1,
    WRRESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    RDIDLE = 1'b0,
    RDDATA = 1'b1
  } rd_state_t;

endpackage

// File: rtl/fir_ctrl_s_axi.sv
// fir_ctrl_s_axi
//   AXI4-Lite slave exposing the control/status registers of a FIR core.
//   Ports:
//     ap_clk, ap_rst_n            clock, synchronous active-low reset
//     AW*/W*/B*                   AXI4-Lite write address/data/response
//     AR*/R*                      AXI4-Lite read address/data
//     interrupt                   registered GIE & (ISR done | ISR ready)
//     ap_start/ap_done/ap_ready/ap_idle   block-level handshake with core
//     x                           input sample register to the core
//     y, y_ap_vld                 core result and its capture strobe
module fir_ctrl_s_axi
  import fir_ctrl_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 5,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [C_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [C_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [C_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [C_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic                      interrupt,
  output logic                      ap_start,
  input  logic                      ap_done,
  input  logic                      ap_ready,
  input  logic                      ap_idle,
  output logic [31:0]               x,
  input  logic [31:0]               y,
  input  logic                      y_ap_vld
);

  localparam logic [C_ADDR_WIDTH-1:0] A_CTRL   = C_ADDR_WIDTH'(ADDR_CTRL);
  localparam logic [C_ADDR_WIDTH-1:0] A_GIE    = C_ADDR_WIDTH'(ADDR_GIE);
  localparam logic [C_ADDR_WIDTH-1:0] A_IER    = C_ADDR_WIDTH'(ADDR_IER);
  localparam logic [C_ADDR_WIDTH-1:0] A_ISR    = C_ADDR_WIDTH'(ADDR_ISR);
  localparam logic [C_ADDR_WIDTH-1:0] A_X      = C_ADDR_WIDTH'(ADDR_X);
  localparam logic [C_ADDR_WIDTH-1:0] A_Y      = C_ADDR_WIDTH'(ADDR_Y);
  localparam logic [C_ADDR_WIDTH-1:0] A_Y_CTRL = C_ADDR_WIDTH'(ADDR_Y_CTRL);

  wr_state_t                   wstate_reg, wstate_next;
  rd_state_t                   rstate_reg, rstate_next;
  logic [C_ADDR_WIDTH-1:0]     waddr_reg;
  logic [C_ADDR_WIDTH-1:0]     raddr;
  logic [C_DATA_WIDTH-1:0]     rdata_reg, rdata_next;
  logic                        aw_hs, w_hs, ar_hs;
  logic                        wr_ctrl, wr_gie, wr_ier, wr_isr, wr_x;
  logic                        ap_start_reg, ap_done_reg, auto_restart_reg;
  logic                        gie_reg, interrupt_reg;
  logic [1:0]                  ier_reg, isr_reg;
  logic [31:0]                 x_reg, x_next;
  logic [31:0]                 y_reg;
  logic                        y_vld_reg;
  logic                        unused_addr_lsbs;

  // Byte offsets inside a word carry no meaning.
  assign unused_addr_lsbs = &{1'b0, AWADDR[1:0], ARADDR[1:0]};
  assign raddr = {ARADDR[C_ADDR_WIDTH-1:2], 2'b00};

  // ---------------- write channel FSM ----------------
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) wstate_reg <= WRIDLE;
    else           wstate_reg <= wstate_next;
  end

  always_comb begin
    wstate_next = wstate_reg;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (wstate_reg)
      WRIDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) wstate_next = WRDATA;
      end
      WRDATA: begin
        WREADY = 1'b1;
        if (WVALID) wstate_next = WRRESP;
      end
      WRRESP: begin
        BVALID = 1'b1;
        if (BREADY) wstate_next = WRIDLE;
      end
      default: wstate_next = WRIDLE;
    endcase
  end

  // ---------------- read channel FSM ----------------
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) rstate_reg <= RDIDLE;
    else           rstate_reg <= rstate_next;
  end

  always_comb begin
    rstate_next = rstate_reg;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    case (rstate_reg)
      RDIDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) rstate_next = RDDATA;
      end
      RDDATA: begin
        RVALID = 1'b1;
        if (RREADY) rstate_next = RDIDLE;
      end
      default: rstate_next = RDIDLE;
    endcase
  end

  assign aw_hs = AWREADY & AWVALID;
  assign w_hs  = WREADY & WVALID;
  assign ar_hs = ARREADY & ARVALID;

  // Control registers only look at byte lane 0.
  assign wr_ctrl = w_hs && (waddr_reg == A_CTRL) && WSTRB[0];
  assign wr_gie  = w_hs && (waddr_reg == A_GIE)  && WSTRB[0];
  assign wr_ier  = w_hs && (waddr_reg == A_IER)  && WSTRB[0];
  assign wr_isr  = w_hs && (waddr_reg == A_ISR)  && WSTRB[0];
  assign wr_x    = w_hs && (waddr_reg == A_X);

  // X merges each written byte lane independently.
  for (genvar gi = 0; gi < 4; gi++) begin : g_x_byte
    assign x_next[gi*8 +: 8] = (wr_x && WSTRB[gi]) ? WDATA[gi*8 +: 8] : x_reg[gi*8 +: 8];
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      waddr_reg        <= '0;
      ap_start_reg     <= 1'b0;
      ap_done_reg      <= 1'b0;
      auto_restart_reg <= 1'b0;
      gie_reg          <= 1'b0;
      ier_reg          <= '0;
      isr_reg          <= '0;
      interrupt_reg    <= 1'b0;
      x_reg            <= '0;
      y_reg            <= '0;
      y_vld_reg        <= 1'b0;
    end else begin
      if (aw_hs) waddr_reg <= {AWADDR[C_ADDR_WIDTH-1:2], 2'b00};

      // ap_start: a written 1 sets it; ap_ready either clears it or,
      // with auto-restart, keeps it asserted for the next run.
      if (wr_ctrl && WDATA[CTRL_START]) ap_start_reg <= 1'b1;
      else if (ap_ready)                ap_start_reg <= auto_restart_reg;

      if (wr_ctrl) auto_restart_reg <= WDATA[CTRL_AUTO_RESTART];

      // Done is sticky until the CTRL read that reports it; a new done
      // in the same cycle must not be lost.
      if (ap_done)                             ap_done_reg <= 1'b1;
      else if (ar_hs && (raddr == A_CTRL))     ap_done_reg <= 1'b0;

      if (wr_gie) gie_reg <= WDATA[GIE_EN];
      if (wr_ier) ier_reg <= WDATA[1:0];

      // ISR: toggle-on-write, hardware set events take priority.
      if (ier_reg[ISR_DONE] && ap_done)   isr_reg[ISR_DONE] <= 1'b1;
      else if (wr_isr)                    isr_reg[ISR_DONE] <= isr_reg[ISR_DONE] ^ WDATA[ISR_DONE];
      if (ier_reg[ISR_READY] && ap_ready) isr_reg[ISR_READY] <= 1'b1;
      else if (wr_isr)                    isr_reg[ISR_READY] <= isr_reg[ISR_READY] ^ WDATA[ISR_READY];

      interrupt_reg <= gie_reg & (|isr_reg);

      x_reg <= x_next;

      if (y_ap_vld) y_reg <= y;
      if (y_ap_vld)                          y_vld_reg <= 1'b1;
      else if (ar_hs && (raddr == A_Y_CTRL)) y_vld_reg <= 1'b0;
    end
  end

  // ---------------- read data path ----------------
  always_comb begin
    rdata_next = '0;
    case (raddr)
      A_CTRL: begin
        rdata_next[CTRL_START]        = ap_start_reg;
        rdata_next[CTRL_DONE]         = ap_done_reg;
        rdata_next[CTRL_IDLE]         = ap_idle;
        rdata_next[CTRL_READY]        = ap_ready;
        rdata_next[CTRL_AUTO_RESTART] = auto_restart_reg;
      end
      A_GIE:    rdata_next[GIE_EN]     = gie_reg;
      A_IER:    rdata_next[1:0]        = ier_reg;
      A_ISR:    rdata_next[1:0]        = isr_reg;
      A_X:      rdata_next             = x_reg;
      A_Y:      rdata_next             = y_reg;
      A_Y_CTRL: rdata_next[Y_CTRL_VLD] = y_vld_reg;
      default:  rdata_next             = '0;
    endcase
  end

  // Read data is captured at the address handshake and held until taken.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)  rdata_reg <= '0;
    else if (ar_hs) rdata_reg <= rdata_next;
  end

  assign RDATA     = rdata_reg;
  assign BRESP     = 2'b00;
  assign RRESP     = 2'b00;
  assign interrupt = interrupt_reg;
  assign ap_start  = ap_start_reg;
  assign x         = x_reg;

endmodule

// File: doc/fir_ctrl_s_axi.md
FIR_CTRL_S_AXI -- requirements
Module: fir_ctrl_s_axi

Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 5, byte address width of the register space.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports: ap_clk  in  1  clock, all logic on its rising edge.
REQ-005 SHALL have ports: ap_rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports: AWADDR in C_ADDR_WIDTH; AWVALID in 1; AWREADY out 1 (write address channel).
REQ-007 SHALL have ports: WDATA in 32; WSTRB in 4; WVALID in 1; WREADY out 1 (write data channel).
REQ-008 SHALL have ports: BRESP out 2; BVALID out 1; BREADY in 1 (write response channel).
REQ-009 SHALL have ports: ARADDR in C_ADDR_WIDTH; ARVALID in 1; ARREADY out 1 (read address channel).
REQ-010 SHALL have ports: RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1 (read data channel).
REQ-011 SHALL have ports: interrupt out 1; ap_start out 1; ap_done in 1; ap_ready in 1; ap_idle in 1 (core control).
REQ-012 SHALL have ports: x out 32 input sample to core; y in 32 core result; y_ap_vld in 1 result strobe.

Function
REQ-013 Register map SHALL be: 0x00 CTRL, 0x04 GIE, 0x08 IER, 0x0C ISR, 0x10 X, 0x18 Y, 0x1C Y_CTRL; other offsets read 0, writes ignored.
REQ-014 Write FSM SHALL have states WRIDLE, WRDATA, WRRESP; AWREADY=1 only in WRIDLE, WREADY=1 only in WRDATA, BVALID=1 only in WRRESP.
REQ-015 Transitions: WRIDLE->WRDATA on AWVALID (address latched); WRDATA->WRRESP on WVALID (register updated same edge); WRRESP->WRIDLE on BREADY.
REQ-016 Read FSM SHALL have states RDIDLE, RDDATA; ARREADY=1 only in RDIDLE; RVALID=1 only in RDDATA; RDATA registered on AR handshake and held until RREADY.
REQ-017 BRESP and RRESP SHALL always be 2'b00 (OKAY).
REQ-018 WSTRB SHALL gate per-byte writes to X; CTRL/GIE/IER/ISR use byte 0 only when WSTRB[0]=1.
REQ-019 CTRL bit0 (ap_start) SHALL set on write of 1, hold until ap_ready=1 and then clear, unless CTRL bit7 (auto_restart) is 1.
REQ-020 CTRL bit1 (ap_done) SHALL set on ap_done=1 and clear on the cycle a CTRL read handshake completes; simultaneous ap_done and clearing read SHALL leave it set.
REQ-021 CTRL bit2 SHALL mirror ap_idle, bit3 mirror ap_ready, bit7 read back auto_restart.
REQ-022 ISR bit0 (done) SHALL set when IER[0]=1 and ap_done=1; bit1 (ready) when IER[1]=1 and ap_ready=1; writing 1 to an ISR bit SHALL toggle it; a set event in the same cycle as a toggle-write SHALL win.
REQ-023 interrupt SHALL equal GIE[0] AND (ISR[0] OR ISR[1]), registered, one cycle after ISR changes.
REQ-024 ap_start output SHALL equal CTRL bit0 combinationally; x SHALL equal the X register.
REQ-025 Y register SHALL capture y when y_ap_vld=1 and set Y_CTRL bit0; Y_CTRL bit0 SHALL clear on completed read of Y_CTRL; capture wins over simultaneous clear.
REQ-026 Read and write FSMs SHALL operate independently; one read and one write may be in flight concurrently.
REQ-027 AWADDR/ARADDR low 2 bits SHALL be ignored (word aligned).

Reset
REQ-028 With ap_rst_n=0 at a rising edge: FSMs SHALL go to WRIDLE/RDIDLE; BVALID, RVALID, interrupt, ap_start=0; CTRL, GIE, IER, ISR, X, Y, Y_CTRL=0; RDATA=0.
REQ-029 Reset mid-transaction SHALL abort it; no response beat SHALL be issued for it after reset.

Structure
REQ-030 Register offsets, bit positions and FSM state encodings SHALL live in shared package fir_ctrl_pkg.
REQ-031 Block SHALL be flat; no sub-modules.

Verification
REQ-032 Write 0x0000_0005 to X with WSTRB=4'hF, BREADY=1 -> BVALID one cycle after W handshake, BRESP=0, x=5.
REQ-033 Write 1 to CTRL, hold ap_ready=0 three cycles then pulse ap_ready and ap_done -> ap_start high until cycle after ap_ready, CTRL read returns bit1=1, second read returns bit1=0.
REQ-034 GIE=1, IER=1, pulse ap_done -> interrupt=1; write ISR=1 -> interrupt=0 next cycle.
REQ-035 Pulse y_ap_vld with y=0xDEAD_BEEF -> read 0x18 returns 0xDEADBEEF, read 0x1C returns 1 then 0.
REQ-036 Issue AR with RREADY=0 for 4 cycles concurrently with a write -> RVALID/RDATA stable, write completes independently.
REQ-037 Assert ap_rst_n=0 while in WRDATA -> AWREADY=1, BVALID=0, all registers 0 next cycle.
